// File: rtl/pixel_renderer.sv
// Three-stage pipelined procedural colour generator: shaded disc centred on the
// frame, drawn over a sky gradient and a checkerboard floor.
module pixel_renderer #(
   parameter int WIDTH   = 320,
   parameter int HEIGHT  = 180,
   parameter int RADIUS  = 60,
   parameter int COORD_W = 33
) (
   input  logic               clk_pixel_in,
   input  logic               rst_in,
   input  logic [COORD_W-1:0] hcount_in,
   input  logic [COORD_W-1:0] vcount_in,
   output logic [7:0]         red_out,
   output logic [7:0]         green_out,
   output logic [7:0]         blue_out
);

   localparam logic [COORD_W-1:0] WIDTH_C  = COORD_W'(WIDTH);
   localparam logic [COORD_W-1:0] HEIGHT_C = COORD_W'(HEIGHT);
   localparam logic signed [11:0] HALF_W   = 12'(WIDTH / 2);
   localparam logic signed [11:0] HALF_H   = 12'(HEIGHT / 2);
   localparam logic [10:0]        FLOOR_Y  = 11'((3 * HEIGHT) / 4);
   localparam logic [23:0]        R2       = 24'(RADIUS * RADIUS);

   // 255 - min(255, v)
   function automatic logic [7:0] fade(input logic [23:0] v);
      logic [7:0] res;
      if (v > 24'd255) begin
         res = 8'd0;
      end else begin
         res = 8'd255 - v[7:0];
      end
      return res;
   endfunction

   logic        active_s;
   logic [10:0] x1_r, y1_r;
   logic        active1_r;

   logic signed [11:0] dx_s, dy_s;
   logic signed [23:0] dx_ext_s, dy_ext_s;
   logic [23:0]        d2_s;
   logic [23:0]        d2_r;
   logic [10:0]        y2_r;
   logic               chk2_r;
   logic               active2_r;

   logic [7:0] red_s, green_s, blue_s;

   // Full-width compare so coordinates >= 2^11 can never alias into the frame.
   assign active_s = (hcount_in < WIDTH_C) && (vcount_in < HEIGHT_C);

   // Stage 1: capture coordinates and active flag
   always_ff @(posedge clk_pixel_in or negedge rst_in) begin
      if (!rst_in) begin
         x1_r      <= 11'd0;
         y1_r      <= 11'd0;
         active1_r <= 1'b0;
      end else begin
         x1_r      <= hcount_in[10:0];
         y1_r      <= vcount_in[10:0];
         active1_r <= active_s;
      end
   end

   assign dx_s     = $signed({1'b0, x1_r}) - HALF_W;
   assign dy_s     = $signed({1'b0, y1_r}) - HALF_H;
   assign dx_ext_s = $signed({{12{dx_s[11]}}, dx_s});
   assign dy_ext_s = $signed({{12{dy_s[11]}}, dy_s});
   assign d2_s     = $unsigned(dx_ext_s * dx_ext_s) + $unsigned(dy_ext_s * dy_ext_s);

   // Stage 2: squared distance, floor parity and pass-through of y / active
   always_ff @(posedge clk_pixel_in or negedge rst_in) begin
      if (!rst_in) begin
         d2_r      <= 24'd0;
         y2_r      <= 11'd0;
         chk2_r    <= 1'b0;
         active2_r <= 1'b0;
      end else begin
         d2_r      <= d2_s;
         y2_r      <= y1_r;
         chk2_r    <= x1_r[4] ^ y1_r[4];
         active2_r <= active1_r;
      end
   end

   // Colour selection: inactive, then disc, then floor, then sky
   always_comb begin
      red_s   = 8'd0;
      green_s = 8'd0;
      blue_s  = 8'd0;
      if (!active2_r) begin
         red_s   = 8'd0;
         green_s = 8'd0;
         blue_s  = 8'd0;
      end else if (d2_r < R2) begin
         red_s   = 8'd255;
         green_s = fade({4'd0, d2_r[23:4]});
         blue_s  = fade({4'd0, d2_r[23:4]});
      end else if (y2_r >= FLOOR_Y) begin
         red_s   = chk2_r ? 8'd128 : 8'd64;
         green_s = chk2_r ? 8'd128 : 8'd64;
         blue_s  = chk2_r ? 8'd128 : 8'd64;
      end else begin
         red_s   = 8'd0;
         green_s = 8'd0;
         blue_s  = fade({13'd0, y2_r});
      end
   end

   // Stage 3: output registers
   always_ff @(posedge clk_pixel_in or negedge rst_in) begin
      if (!rst_in) begin
         red_out   <= 8'd0;
         green_out <= 8'd0;
         blue_out  <= 8'd0;
      end else begin
         red_out   <= red_s;
         green_out <= green_s;
         blue_out  <= blue_s;
      end
   end

endmodule

// File: tb/tb_pixel_renderer.sv
// Scoreboard bench for pixel_renderer: directed vectors plus a diagonal sweep
// with a mid-stream asynchronous reset.
module tb_pixel_renderer;

   localparam int W  = 320;
   localparam int H  = 180;
   localparam int R  = 60;
   localparam int CW = 33;
   localparam logic [CW-1:0] OFF_X = 33'h1_0000_0000;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [CW-1:0] hc, vc;
   logic [7:0]    r, g, b;

   always #5 clk = ~clk;

   pixel_renderer #(.WIDTH(W), .HEIGHT(H), .RADIUS(R), .COORD_W(CW)) dut (
      .clk_pixel_in (clk),
      .rst_in       (rst_n),
      .hcount_in    (hc),
      .vcount_in    (vc),
      .red_out      (r),
      .green_out    (g),
      .blue_out     (b)
   );

   typedef struct {
      logic [23:0] rgb;
      int          tag;
   } exp_t;

   exp_t       exp_q[$];
   exp_t       mon_e;
   int         checks = 0;
   int         errors = 0;
   logic       issue  = 1'b0;
   logic       mon_en = 1'b0;
   logic [2:0] issue_d;

   // Tracks which output slots carry a scoreboarded pixel; flushed by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) issue_d <= 3'b000;
      else        issue_d <= {issue_d[1:0], issue};
   end

   // Monitor: scored slots pop the queue, all other slots must be black
   always @(posedge clk) begin
      #1;
      if (mon_en) begin
         checks++;
         if (issue_d[2]) begin
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL scoreboard_empty got=%06h exp=none", {r, g, b});
            end else begin
               mon_e = exp_q.pop_front();
               if ({r, g, b} !== mon_e.rgb) begin
                  errors++;
                  $display("FAIL pixel tag=%0d got=%06h exp=%06h", mon_e.tag, {r, g, b}, mon_e.rgb);
               end
            end
         end else if ({r, g, b} !== 24'h000000) begin
            errors++;
            $display("FAIL idle_zero got=%06h exp=000000", {r, g, b});
         end
      end
   end

   function automatic logic [23:0] model(input logic [CW-1:0] x, input logic [CW-1:0] y);
      int xi, yi, dx, dy, d2, v;
      if (x >= CW'(W) || y >= CW'(H)) return 24'h000000;
      xi = int'(x[15:0]);
      yi = int'(y[15:0]);
      dx = xi - W / 2;
      dy = yi - H / 2;
      d2 = dx * dx + dy * dy;
      if (d2 < R * R) begin
         v = d2 / 16;
         if (v > 255) v = 255;
         return {8'd255, 8'(255 - v), 8'(255 - v)};
      end
      if (yi >= (3 * H) / 4) begin
         if ((((xi / 16) ^ (yi / 16)) & 1) == 1) return 24'h808080;
         return 24'h404040;
      end
      v = (yi > 255) ? 255 : yi;
      return {16'h0000, 8'(255 - v)};
   endfunction

   task automatic drive(input logic [CW-1:0] x, input logic [CW-1:0] y,
                        input logic [23:0] rgb, input int tag);
      hc    = x;
      vc    = y;
      issue = 1'b1;
      exp_q.push_back('{rgb: rgb, tag: tag});
      @(negedge clk);
   endtask

   task automatic check_zero(input string name);
      checks++;
      if ({r, g, b} !== 24'h000000) begin
         errors++;
         $display("FAIL %s got=%06h exp=000000", name, {r, g, b});
      end
   endtask

   localparam int ND = 16;
   logic [CW-1:0] dir_x   [ND] = '{33'd10, 33'd160, 33'd130, 33'd100, 33'd0, 33'd16, 33'd159, 33'd159,
                                   33'd320, 33'd10, 33'h0_0010_0000, 33'd319, 33'd319, 33'd0, 33'd160, 33'd160};
   logic [CW-1:0] dir_y   [ND] = '{33'd10, 33'd90, 33'd90, 33'd90, 33'd170, 33'd170, 33'd135, 33'd170,
                                   33'd10, 33'd180, 33'd10, 33'd179, 33'd0, 33'd179, 33'd30, 33'd31};
   logic [23:0]   dir_rgb [ND] = '{24'h0000F5, 24'hFFFFFF, 24'hFFC7C7, 24'h0000A5, 24'h404040, 24'h808080,
                                   24'hFF8181, 24'h808080, 24'h000000, 24'h000000, 24'h000000, 24'h404040,
                                   24'h0000FF, 24'h808080, 24'h0000E1, 24'hFF2626};

   initial begin
      rst_n = 1'b1;
      hc    = 33'd160;
      vc    = 33'd90;
      // Fill the pipeline with a white disc pixel so the async clear is visible.
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_zero("reset_async");
      hc     = OFF_X;
      vc     = OFF_X;
      mon_en = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < ND; i++) begin
         drive(dir_x[i], dir_y[i], dir_rgb[i], i);
      end

      for (int i = 0; i <= 400; i++) begin
         if (i == 200) begin
            rst_n = 1'b0;
            issue = 1'b0;
            hc    = OFF_X;
            vc    = OFF_X;
            #1;
            check_zero("reset_mid");
            exp_q.delete();
            repeat (2) @(negedge clk);
            check_zero("reset_hold");
            rst_n = 1'b1;
         end
         drive(CW'(i), CW'(300 - i), model(CW'(i), CW'(300 - i)), 1000 + i);
      end

      issue = 1'b0;
      hc    = OFF_X;
      vc    = OFF_X;
      repeat (5) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain got=%0d exp=0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
